// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator that copies a block of 32-bit words from one
// byte address to another through one port of the dual-port memory.
// Two cycles per word (READ then WRITE), plus one DONE cycle per transfer.
// A start pulse seen while busy is dropped; it is never queued.
//
// Ports:
//   clk, rstb            clock; synchronous active-high reset
//   start, abort         one-cycle request (IDLE only); terminate (READ/WRITE)
//   src_addr, dst_addr   byte addresses, latched on start, aligned to words
//   count                number of words, latched on start
//   busy, done, aborted  status: busy in READ/WRITE/DONE, done pulse,
//                        aborted flag held until the next start
//   words_done           words written so far, held until the next start
//   mem_wr_ena, mem_addr, mem_din, mem_dout   memory port (read data valid
//                        one cycle after its address)
module mem_copy_dma #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  src_addr,
  input  logic [N-1:0]  dst_addr,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] words_done,
  output logic          mem_wr_ena,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_din,
  input  logic [N-1:0]  mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  cur_src;
  logic [N-1:0]  cur_dst;
  logic [CW-1:0] remaining;
  // Last values driven on the memory port; replayed in IDLE and DONE so
  // the address/data lines only move while a word is actually in flight.
  logic [N-1:0]  last_addr;
  logic [N-1:0]  last_din;

  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_wr_ena = 1'b0;
    mem_addr   = last_addr;
    mem_din    = last_din;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_addr  = cur_src;
        state_nxt = abort ? DONE : WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        mem_addr   = cur_dst;
        mem_din    = mem_dout;
        // Reset is sampled on the same edge the memory would commit the
        // write, so the enable is masked to keep a reset from landing a
        // partial copy.
        mem_wr_ena = ~rstb;
        state_nxt  = (abort || remaining == CW'(1)) ? DONE : READ;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
      words_done <= '0;
      aborted    <= 1'b0;
      last_addr  <= '0;
      last_din   <= '0;
    end else begin
      last_addr <= mem_addr;
      last_din  <= mem_din;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src    <= {src_addr[N-1:2], 2'b00};
            cur_dst    <= {dst_addr[N-1:2], 2'b00};
            remaining  <= count;
            words_done <= '0;
            aborted    <= 1'b0;
          end
        end
        READ: begin
          if (abort) begin
            aborted <= 1'b1;
          end
        end
        WRITE: begin
          // The write in flight always completes; abort only stops the
          // next word from being fetched.
          cur_src    <= cur_src + N'(4);
          cur_dst    <= cur_dst + N'(4);
          words_done <= words_done + CW'(1);
          remaining  <= remaining - CW'(1);
          if (abort) begin
            aborted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] words_done;
  logic        mem_wr_ena;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  // Word-addressed memory model: key is byte address [31:2].
  logic [31:0] mem [logic [29:0]];

  always #5 clk = ~clk;

  mem_copy_dma #(.N(32), .CW(16)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [31:0] rd(input logic [29:0] k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  // Read-before-write memory port, one cycle read latency.
  always @(posedge clk) begin
    mem_dout <= rd(mem_addr[31:2]);
    if (mem_wr_ena) begin
      mem[mem_addr[31:2]] = mem_din;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0;
    tick(); tick();
    rstb = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL reset_words_done: got %0d expected 0", words_done); end
    checks++; if (mem_wr_ena !== 1'b0) begin errors++; $display("FAIL reset_wr_ena: got %b expected 0", mem_wr_ena); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_mem_din: got %h expected 0", mem_din); end
  endtask

  task automatic test_basic_copy();
    int n;
    int wr0;
    for (int i = 0; i < 4; i++) mem[30'(i)] = 32'hA0 + i;
    for (int i = 0; i < 4; i++) mem[30'h1000_0040 + 30'(i)] = 32'h0;
    wr0 = wr_cnt;
    src_addr = 32'h0; dst_addr = 32'h4000_0100; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 9", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 1", busy); end
    checks++; if (words_done !== 16'd4) begin errors++; $display("FAIL basic_words_done: got %0d expected 4", words_done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted: got %b expected 0", aborted); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd(30'h1000_0040 + 30'(i)) !== 32'hA0 + i) begin
        errors++; $display("FAIL basic_imem_%0d: got %h expected %h", i, rd(30'h1000_0040 + 30'(i)), 32'hA0 + i);
      end
    end
    checks++; if (wr_cnt - wr0 !== 4) begin errors++; $display("FAIL basic_write_count: got %0d expected 4", wr_cnt - wr0); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_zero_length();
    int wr0;
    wr0 = wr_cnt;
    src_addr = 32'h0; dst_addr = 32'h4000_0100; count = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL zero_words_done: got %0d expected 0", words_done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy); end
    checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt - wr0); end
  endtask

  task automatic test_misaligned();
    mem[30'h4] = 32'h1234_5678;
    mem[30'h8] = 32'h0;
    src_addr = 32'h13; dst_addr = 32'h22; count = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_addr !== 32'h10 || mem_wr_ena !== 1'b0) begin errors++; $display("FAIL mis_read: got addr=%h we=%b expected 00000010 0", mem_addr, mem_wr_ena); end
    tick();
    checks++; if (mem_addr !== 32'h20 || mem_wr_ena !== 1'b1) begin errors++; $display("FAIL mis_write: got addr=%h we=%b expected 00000020 1", mem_addr, mem_wr_ena); end
    checks++; if (mem_din !== 32'h1234_5678) begin errors++; $display("FAIL mis_din: got %h expected 12345678", mem_din); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mis_done_cycle3: got %b expected 1", done); end
    checks++; if (mem_wr_ena !== 1'b0 || mem_addr !== 32'h20) begin errors++; $display("FAIL mis_hold: got we=%b addr=%h expected 0 00000020", mem_wr_ena, mem_addr); end
    checks++; if (rd(30'h8) !== 32'h1234_5678) begin errors++; $display("FAIL mis_mem: got %h expected 12345678", rd(30'h8)); end
    tick();
  endtask

  task automatic test_abort();
    int wr0;
    for (int i = 0; i < 8; i++) mem[30'h40 + 30'(i)] = 32'hB0 + i;
    for (int i = 0; i < 8; i++) mem[30'h80 + 30'(i)] = 32'hFFFF_0000 + i;
    wr0 = wr_cnt;
    src_addr = 32'h100; dst_addr = 32'h200; count = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (mem_wr_ena !== 1'b1 || mem_addr !== 32'h208) begin errors++; $display("FAIL abort_third_write: got we=%b addr=%h expected 1 00000208", mem_wr_ena, mem_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || aborted !== 1'b1) begin errors++; $display("FAIL abort_done: got done=%b aborted=%b expected 1 1", done, aborted); end
    checks++; if (words_done !== 16'd3) begin errors++; $display("FAIL abort_words_done: got %0d expected 3", words_done); end
    checks++; if (wr_cnt - wr0 !== 3) begin errors++; $display("FAIL abort_writes: got %0d expected 3", wr_cnt - wr0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd(30'h80 + 30'(i)) !== 32'hB0 + i) begin
        errors++; $display("FAIL abort_dst_%0d: got %h expected %h", i, rd(30'h80 + 30'(i)), 32'hB0 + i);
      end
    end
    checks++; if (rd(30'h83) !== 32'hFFFF_0003) begin errors++; $display("FAIL abort_dst_3_untouched: got %h expected ffff0003", rd(30'h83)); end
    tick();
    checks++; if (aborted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_hold: got aborted=%b done=%b expected 1 0", aborted, done); end
  endtask

  task automatic test_reset_mid();
    int n;
    int wr0;
    for (int i = 0; i < 4; i++) mem[30'hC0 + 30'(i)] = 32'h5555_0000 + i;
    wr0 = wr_cnt;
    src_addr = 32'h0; dst_addr = 32'h300; count = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if (mem_wr_ena !== 1'b1 || mem_addr !== 32'h304) begin errors++; $display("FAIL rmid_in_write: got we=%b addr=%h expected 1 00000304", mem_wr_ena, mem_addr); end
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL rmid_status: got busy=%b done=%b aborted=%b expected 0 0 0", busy, done, aborted); end
    checks++; if (words_done !== 16'd0 || mem_wr_ena !== 1'b0) begin errors++; $display("FAIL rmid_counts: got wd=%0d we=%b expected 0 0", words_done, mem_wr_ena); end
    checks++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin errors++; $display("FAIL rmid_bus: got addr=%h din=%h expected 0 0", mem_addr, mem_din); end
    checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL rmid_writes: got %0d expected 1", wr_cnt - wr0); end
    checks++; if (rd(30'hC1) !== 32'h5555_0001) begin errors++; $display("FAIL rmid_no_partial: got %h expected 55550001", rd(30'hC1)); end
    src_addr = 32'h0; dst_addr = 32'h300; count = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL rmid_restart_cycle: got %0d expected 5", n); end
    checks++; if (words_done !== 16'd2 || aborted !== 1'b0) begin errors++; $display("FAIL rmid_restart_status: got wd=%0d ab=%b expected 2 0", words_done, aborted); end
    checks++; if (rd(30'hC1) !== 32'hA1) begin errors++; $display("FAIL rmid_restart_data: got %h expected 000000a1", rd(30'hC1)); end
    tick();
  endtask

  task automatic test_busy_wrap();
    int n;
    mem[30'h3FFF_FFFF] = 32'hC0C0_0001;
    mem[30'h100] = 32'h0;
    mem[30'h101] = 32'h0;
    src_addr = 32'hFFFF_FFFC; dst_addr = 32'h400; count = 16'd2; start = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_read: got %h expected fffffffc", mem_addr); end
    // A second request during the transfer must be dropped.
    src_addr = 32'h100; dst_addr = 32'h500; count = 16'd7;
    tick();
    start = 1'b0;
    tick();
    checks++; if (mem_addr !== 32'h0 || mem_wr_ena !== 1'b0) begin errors++; $display("FAIL wrap_second_read: got addr=%h we=%b expected 0 0", mem_addr, mem_wr_ena); end
    n = 3;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 5", n); end
    checks++; if (words_done !== 16'd2) begin errors++; $display("FAIL busy_start_words_done: got %0d expected 2", words_done); end
    checks++; if (rd(30'h100) !== 32'hC0C0_0001 || rd(30'h101) !== 32'hA0) begin errors++; $display("FAIL wrap_data: got %h %h expected c0c00001 000000a0", rd(30'h100), rd(30'h101)); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_not_queued: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_misaligned();
    test_abort();
    test_reset_mid();
    test_busy_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
